// File: rtl/shift_pkg.sv
// Shared constants for the shift_pipe execution unit: datapath widths and opcodes.
package shift_pkg;

   localparam int N = 16;
   localparam int C = 4;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/barrel_rotl.sv
// Combinational N-bit left rotator: log stages of 2:1 muxes, stage k rotates by 2**k.
module barrel_rotl
   import shift_pkg::*;
(
   input  logic [N-1:0] d,
   input  logic [C-1:0] amt,
   output logic [N-1:0] q
);

   logic [N-1:0] stage [0:C];

   assign stage[0] = d;

   for (genvar k = 0; k < C; k++) begin : g_stage
      localparam int SH = 1 << k;
      assign stage[k+1] = amt[k] ? {stage[k][N-1-SH:0], stage[k][N-1:N-SH]} : stage[k];
   end

   assign q = stage[C];

endmodule

// File: rtl/shift_pipe.sv
// Two-stage shift/rotate unit: every op becomes a left rotate plus a result mask.
// Optional registered zero flag when SHIFT_ZERO_FLAG_EN is defined.
module shift_pipe
   import shift_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] data_in,
   input  logic [C-1:0] cnt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] data_out
`ifdef SHIFT_ZERO_FLAG_EN
   ,
   output logic         zero
`endif
);

   localparam logic [N-1:0] ALL_ONES = '1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; in_ready depends on out_ready combinationally, there is no skid buffer.
   logic         adv1;
   logic         adv2;

   logic         v1;
   logic [N-1:0] d1;
   logic [C-1:0] amt1;
   logic [N-1:0] mask1;

   logic [C-1:0] neg_cnt;
   logic [C-1:0] amt_d;
   logic [N-1:0] mask_d;
   logic [N-1:0] rot_q;
   logic [N-1:0] result;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !v1 || adv2;
   assign in_ready = adv1;

   // A right move by cnt equals a left rotate by (N - cnt) mod N.
   assign neg_cnt = {C{1'b0}} - cnt;

   always_comb begin
      amt_d  = cnt;
      mask_d = ALL_ONES;
      case (op)
         OP_SLL: mask_d = ALL_ONES << cnt;
         OP_ROR: amt_d  = neg_cnt;
         OP_SRL: begin
            amt_d  = neg_cnt;
            mask_d = ALL_ONES >> cnt;
         end
         default: ;
      endcase
   end

   barrel_rotl u_rotl (
      .d   (d1),
      .amt (amt1),
      .q   (rot_q)
   );

   assign result = rot_q & mask1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         d1        <= '0;
         amt1      <= '0;
         mask1     <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
`ifdef SHIFT_ZERO_FLAG_EN
         zero      <= 1'b0;
`endif
      end else begin
         if (adv1) begin
            v1    <= in_valid;
            d1    <= data_in;
            amt1  <= amt_d;
            mask1 <= mask_d;
         end
         if (adv2) begin
            out_valid <= v1;
            data_out  <= result;
`ifdef SHIFT_ZERO_FLAG_EN
            zero      <= ~|result;
`endif
         end
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus randomized traffic against a queue model.
module tb_shift_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [15:0] data_in;
   logic [3:0]  cnt;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] data_out;
`ifdef SHIFT_ZERO_FLAG_EN
   logic        zero;
`endif

   logic        rand_ready;
   logic        or_fixed;
   logic        rnd_ready;
   logic        chk_lat;

   int          n_checks;
   int          n_errors;
   int          cyc;

   logic [15:0] exp_q[$];
   int          acc_q[$];

   shift_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .data_in   (data_in),
      .cnt       (cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
`ifdef SHIFT_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "timeout");
   end

   always @(posedge clk) begin
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   assign out_ready = rand_ready ? rnd_ready : or_fixed;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h required=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model straight from the op definitions, using wide unsigned arithmetic.
   function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] d,
                                             input logic [3:0] c);
      int unsigned x;
      int unsigned n;
      int unsigned r;
      x = 32'(d);
      n = 32'(c);
      case (o)
         2'd0:    r = (x << n) | (x >> (16 - n));
         2'd1:    r = x << n;
         2'd2:    r = (x >> n) | (x << (16 - n));
         default: r = x >> n;
      endcase
      return r[15:0];
   endfunction

   // scoreboard: record accepts, compare consumed results in order
   always @(negedge clk) begin
      logic [15:0] e;
      int          a;
      cyc++;
      if (!rst) begin
         if (out_valid && out_ready) begin
            check("spurious_out", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("data_out", 32'(data_out), 32'(e));
`ifdef SHIFT_ZERO_FLAG_EN
               check("zero_flag", 32'(zero), 32'(e == 16'h0000));
`endif
               if (chk_lat) check("latency", 32'(cyc - a), 32'd2);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(op, data_in, cnt));
            acc_q.push_back(cyc);
         end
      end
   end

   // driver tasks
   task automatic send(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c);
      logic acc;
      acc      = 1'b0;
      op       = o;
      data_in  = d;
      cnt      = c;
      in_valid = 1'b1;
      for (int n = 0; n < 60 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      or_fixed   = 1'b1;
      rand_ready = 1'b0;
      for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
         @(posedge clk);
         #1;
      end
      idle(2);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] exp_a;
      n_checks   = 0;
      n_errors   = 0;
      cyc        = 0;
      chk_lat    = 1'b0;
      rand_ready = 1'b0;
      or_fixed   = 1'b1;
      rst        = 1'b1;
      in_valid   = 1'b0;
      op         = 2'd0;
      data_in    = 16'h0000;
      cnt        = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'h0000);
      check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFT_ZERO_FLAG_EN
      check("rst_zero", 32'(zero), 32'd0);
`endif
      @(posedge clk);
      #1;

      // op coverage, back-to-back, fixed latency
      chk_lat = 1'b1;
      check("model_rol", 32'(ref_model(2'd0, 16'h8001, 4'd1)), 32'h0003);
      check("model_srl", 32'(ref_model(2'd3, 16'h8000, 4'd15)), 32'h0001);
      send(2'd0, 16'h8001, 4'd1);
      send(2'd1, 16'h8001, 4'd4);
      send(2'd2, 16'h0001, 4'd1);
      send(2'd3, 16'h8000, 4'd15);
      idle(4);
      chk_lat = 1'b0;
      check("op_cov_drained", 32'(exp_q.size()), 32'd0);

      // count zero passes the operand through
      for (int o = 0; o < 4; o++) send(2'(o), 16'hA5C3, 4'd0);
      for (int o = 0; o < 4; o++) send(2'(o), 16'h0000, 4'd0);
      drain();

      // backpressure: two buffered, third held off
      or_fixed = 1'b0;
      exp_a    = 16'hFFF0;
      send(2'd1, 16'hFFFF, 4'd4);
      send(2'd2, 16'h1234, 4'd4);
      op       = 2'd3;
      data_in  = 16'hF00F;
      cnt      = 4'd8;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data", 32'(data_out), 32'(exp_a));
         @(posedge clk);
         #1;
      end
      or_fixed = 1'b1;
      send(2'd3, 16'hF00F, 4'd8);
      drain();

      // reset with both stages occupied
      or_fixed = 1'b0;
      send(2'd0, 16'h1111, 4'd3);
      send(2'd1, 16'h2222, 4'd5);
      rst      = 1'b1;
      op       = 2'd0;
      data_in  = 16'hBEEF;
      cnt      = 4'd1;
      in_valid = 1'b1;
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data_out", 32'(data_out), 32'h0000);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      or_fixed = 1'b1;
      idle(6);

      // randomized: every op x every count, random operands, gaps and backpressure
      rand_ready = 1'b1;
      for (int o = 0; o < 4; o++) begin
         for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 2; r++) begin
               idle($urandom_range(0, 2));
               send(2'(o), 16'($urandom), 4'(c));
            end
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
